// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pkg
// Description : Shared Ascon definitions: round constants, round counts,
//               permutation-controller state encoding and round clamping.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

    localparam int NB_ROUNDS_A = 12;
    localparam int NB_ROUNDS_B = 6;

    // Round constants indexed by absolute round index 0..11.
    localparam logic [7:0] ROUND_CONSTANTS [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } t_perm_fsm;

    // A zero or out-of-range request runs the full p^a permutation.
    function automatic logic [3:0] clamp_rounds(input logic [3:0] n);
        if ((n == 4'd0) || (n > 4'(NB_ROUNDS_A))) begin
            return 4'(NB_ROUNDS_A);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_counter.sv
`default_nettype none
// ============================================================================
// Module      : round_counter
// Description : Loadable up-counter for the permutation round index with a
//               terminal flag at the last round. Saturates at the terminal
//               value so it can never wrap.
// Ports       : clock       in  rising-edge clock
//               reset_n     in  async active-low reset
//               load        in  capture load_value
//               load_value  in  start round index
//               enable      in  advance one round
//               count       out current round index
//               terminal    out count == MAX_ROUNDS-1
// Revision    : 1.0 - initial release
// ============================================================================
module round_counter #(
    parameter int MAX_ROUNDS = 12,
    parameter int CNT_W      = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_ROUNDS - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = (r_count == C_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && !w_terminal) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count    = r_count;
    assign terminal = w_terminal;

endmodule
`default_nettype wire

// File: rtl/permutation_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : permutation_ctrl
// Description : Sequences the Ascon permutation datapath for N rounds
//               (p^a = 12, p^b = 6 or 8). Runs rounds MAX_ROUNDS-N .. 11 so
//               the constant adder sees the correct absolute round index.
//               Result completion uses a valid/ack handshake.
// Ports       : clock        in  rising-edge clock
//               reset_n      in  async active-low reset
//               i_start      in  request, accepted when i_start & o_ready
//               i_nb_rounds  in  rounds requested (0 or >12 means 12)
//               o_ready      out idle, may accept a request
//               o_load       out state register loads external input
//               o_round_en   out state register loads datapath output
//               o_round      out round index for the constant adder
//               o_valid      out permutation result available
//               i_ack        in  consumer took the result
//               o_busy       out loading or running rounds
// Revision    : 1.0 - initial release
// ============================================================================
module permutation_ctrl
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = 12,
    parameter int CNT_W      = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_nb_rounds,
    output logic             o_ready,
    output logic             o_load,
    output logic             o_round_en,
    output logic [CNT_W-1:0] o_round,
    output logic             o_valid,
    input  logic             i_ack,
    output logic             o_busy
);

    t_perm_fsm        r_state;
    t_perm_fsm        w_next_state;
    logic [CNT_W-1:0] r_k0;
    logic [CNT_W-1:0] w_count;
    logic             w_terminal;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && i_start;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Start index is captured at accept so later changes on i_nb_rounds
    // cannot affect a running permutation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_k0 <= '0;
        end else if (w_accept) begin
            r_k0 <= CNT_W'(MAX_ROUNDS) - CNT_W'(clamp_rounds(4'(i_nb_rounds)));
        end
    end

    round_counter #(
        .MAX_ROUNDS (MAX_ROUNDS),
        .CNT_W      (CNT_W)
    ) u_round_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (r_state == LOAD),
        .load_value (r_k0),
        .enable     (r_state == ROUND),
        .count      (w_count),
        .terminal   (w_terminal)
    );

    // Next state and outputs; outputs depend on registered state only.
    always_comb begin
        w_next_state = r_state;
        o_ready      = 1'b0;
        o_load       = 1'b0;
        o_round_en   = 1'b0;
        o_valid      = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                o_load       = 1'b1;
                o_busy       = 1'b1;
                w_next_state = ROUND;
            end
            ROUND: begin
                o_round_en = 1'b1;
                o_busy     = 1'b1;
                if (w_terminal) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // o_ready stays low here so the ack cycle cannot accept.
                o_valid = 1'b1;
                if (i_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_round = w_count;

endmodule
`default_nettype wire
